// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and helpers for the PS/2 Set-2 keycode decoder.
package ps2_pkg;

  // Scan-code prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard control/response bytes diverted to the sideband
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PS2_ERR0     = 8'h00;
  localparam logic [7:0] PS2_ERRF     = 8'hFF;

  // Event word layout: {brk, ext, code[7:0]}
  localparam int unsigned EVT_W       = 10;
  localparam int unsigned EVT_BRK_BIT = 9;
  localparam int unsigned EVT_EXT_BIT = 8;

  // Pause is E1 followed by seven more bytes
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } ps2_state_e;

  // Inter-byte timeout expressed in system clock cycles
  function automatic int unsigned tmo_cycles(input int unsigned sysclk_mhz,
                                             input int unsigned timeout_us);
    return sysclk_mhz * timeout_us;
  endfunction

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    logic r;
    r = 1'b0;
    case (b)
      PS2_ACK, PS2_BAT_OK, PS2_ECHO, PS2_RESEND,
      PS2_BAT_FAIL, PS2_ERR0, PS2_ERRF: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead event FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped and flagged.
module ps2_evt_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [Width-1:0]           o_data,
  output logic [$clog2(Depth):0]     o_count,
  output logic                       o_drop
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == CntW'(Depth));
  assign w_pop     = i_pop && w_valid;
  assign w_push_ok = i_push && (!w_full || w_pop);

  assign o_valid = w_valid;
  assign o_data  = w_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;
  assign o_drop  = i_push && !w_push_ok;

  // Storage write; contents need no reset because the count gates the output
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since Depth is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 Set-2 scan-code decoder: strips E0/F0 prefixes, folds the Pause
// sequence into one event, diverts control bytes to a sideband and buffers
// key events in a show-ahead FIFO.
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned SYSCLK     = 50,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_rx_valid,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_error,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [EVT_W-1:0]              o_evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_evt_count,
  output logic                          o_ctrl_valid,
  output logic [7:0]                    o_ctrl_byte,
  output logic                          o_overflow,
  input  logic                          i_clr_overflow
);

  localparam int unsigned TmoCycles = tmo_cycles(SYSCLK, TIMEOUT_US);
  localparam int unsigned TmoW      = $clog2(TmoCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TmoCycles - 1);

  ps2_state_e       r_state;
  ps2_state_e       w_state_d;
  logic [2:0]       r_skip;
  logic [2:0]       w_skip_d;
  logic [TmoW-1:0]  r_tmo_cnt;
  logic             w_tmo_hit;

  logic             w_push;
  logic [EVT_W-1:0] w_push_data;
  logic             w_ctrl;

  logic             r_push;
  logic [EVT_W-1:0] r_push_data;
  logic             r_ctrl_valid;
  logic [7:0]       r_ctrl_byte;
  logic             r_overflow;

  logic             w_fifo_drop;

  assign w_tmo_hit = (r_state != StIdle) && (r_tmo_cnt == TmoLast);

  // Decoder next-state, event build and control-byte detection
  always_comb begin
    w_state_d   = r_state;
    w_skip_d    = r_skip;
    w_push      = 1'b0;
    w_push_data = '0;
    w_ctrl      = 1'b0;
    if (i_rx_valid) begin
      if (i_rx_error) begin
        w_state_d = StIdle;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_rx_data == PS2_EXT) begin
              w_state_d = StExt;
            end else if (i_rx_data == PS2_BRK) begin
              w_state_d = StBrk;
            end else if (i_rx_data == PS2_PAUSE) begin
              w_state_d = StPause;
              w_skip_d  = PAUSE_SKIP;
            end else if (is_ctrl_byte(i_rx_data)) begin
              w_ctrl = 1'b1;
            end else begin
              w_push      = 1'b1;
              w_push_data = {1'b0, 1'b0, i_rx_data};
            end
          end
          StExt: begin
            if (i_rx_data == PS2_BRK) begin
              w_state_d = StExtBrk;
            end else if (i_rx_data != PS2_EXT) begin
              w_push      = 1'b1;
              w_push_data = {1'b0, 1'b1, i_rx_data};
              w_state_d   = StIdle;
            end
          end
          StBrk: begin
            w_push      = 1'b1;
            w_push_data = {1'b1, 1'b0, i_rx_data};
            w_state_d   = StIdle;
          end
          StExtBrk: begin
            w_push      = 1'b1;
            w_push_data = {1'b1, 1'b1, i_rx_data};
            w_state_d   = StIdle;
          end
          StPause: begin
            // Byte contents are ignored; only the count matters
            w_skip_d = r_skip - 1'b1;
            if (r_skip == 3'd1) begin
              w_push      = 1'b1;
              w_push_data = {1'b0, 1'b1, PS2_PAUSE};
              w_state_d   = StIdle;
            end
          end
          default: w_state_d = StIdle;
        endcase
      end
    end else if (w_tmo_hit) begin
      w_state_d = StIdle;
    end
  end

  // FSM state and Pause skip counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_d;
      r_skip  <= w_skip_d;
    end
  end

  // Inter-byte timeout: restarts on each byte, runs only mid-sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (i_rx_valid || (r_state == StIdle) || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Registered push towards the FIFO and control-byte sideband pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_ctrl_valid <= 1'b0;
      r_ctrl_byte  <= '0;
    end else begin
      r_push       <= w_push;
      r_push_data  <= w_push_data;
      r_ctrl_valid <= w_ctrl;
      if (w_ctrl) begin
        r_ctrl_byte <= i_rx_data;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_fifo_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .Width (EVT_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .i_pop       (i_evt_ready),
    .o_valid     (o_evt_valid),
    .o_data      (o_evt_data),
    .o_count     (o_evt_count),
    .o_drop      (w_fifo_drop)
  );

  assign o_ctrl_valid = r_ctrl_valid;
  assign o_ctrl_byte  = r_ctrl_byte;
  assign o_overflow   = r_overflow;

endmodule
